// File: rtl/multiplier_pkg.sv
// Shared constants and types for the sequential radix-4 Booth multiplier.
package multiplier_pkg;
    localparam int OP_W       = 32;                  // operand width
    localparam int ACC_W      = 34;                  // accumulator width (holds +/-2M)
    localparam int P_W        = ACC_W + OP_W + 1;    // {A, Q, q_-1}
    localparam int MULT_STEPS = 16;                  // radix-4: two bits per step
    localparam int CNT_W      = $clog2(MULT_STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MULT_STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Partial-product selector produced by the Booth recoder
    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_sel_t;
endpackage

// File: rtl/multiplier_booth_r4_recoder.sv
// Radix-4 Booth recoder: maps the window {Q[1:0], q_-1} onto a selector.
module booth_r4_recoder
    import multiplier_pkg::*;
(
    input  logic [2:0]  window,
    output booth_sel_t  sel
);
    // Standard radix-4 Booth table
    always_comb begin
        sel = ZERO;
        case (window)
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100:         sel = NEG2;
            3'b101, 3'b110: sel = NEG1;
            default:        sel = ZERO;
        endcase
    end
endmodule

// File: rtl/multiplier.sv
// Sequential signed 32x32 multiplier, radix-4 Booth, 16 steps.
// Optional build macro MULT_HI_WORD_EN adds the registered high-word output.
module multiplier
    import multiplier_pkg::*;
(
    input  logic            clk,
    input  logic            clr,
    input  logic            ctrl_MULT,
    input  logic [OP_W-1:0] data_operandA,
    input  logic [OP_W-1:0] data_operandB,
    output logic [OP_W-1:0] mult_result,
    output logic            mult_exception,
    output logic            mult_ready
`ifdef MULT_HI_WORD_EN
    ,
    output logic [OP_W-1:0] mult_result_hi
`endif
);
    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [ACC_W-1:0]        mcand;
    logic [P_W-1:0]          p_reg;
    booth_sel_t              sel;
    logic [ACC_W-1:0]        pp;
    logic [ACC_W-1:0]        a_sum;
    logic signed [P_W-1:0]   p_sum;
    logic [P_W-1:0]          p_step;
    logic [2*OP_W-1:0]       product;
    logic                    ovf;
    logic                    enter_done;

    booth_r4_recoder u_recoder (
        .window (p_reg[2:0]),
        .sel    (sel)
    );

    // Partial-product select, accumulate, then arithmetic shift by two
    always_comb begin
        pp = '0;
        case (sel)
            POS1:    pp = mcand;
            POS2:    pp = mcand << 1;
            NEG1:    pp = -mcand;
            NEG2:    pp = -(mcand << 1);
            default: pp = '0;
        endcase
    end

    assign a_sum   = p_reg[P_W-1 -: ACC_W] + pp;
    assign p_sum   = {a_sum, p_reg[OP_W:0]};
    assign p_step  = p_sum >>> 2;
    // After the last step {A[31:0], Q} is the full product
    assign product = p_step[2*OP_W:1];
    // Overflow when product[63:31] is not a pure sign extension
    assign ovf     = !((&product[2*OP_W-1:OP_W-1]) || !(|product[2*OP_W-1:OP_W-1]));

    assign enter_done = (state == RUN) && !ctrl_MULT && (cnt == LAST_STEP);
    assign mult_ready = (state == DONE);

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a start strobe in any state (re)loads and runs
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ctrl_MULT) state_nxt = RUN;
            RUN:  if (!ctrl_MULT && cnt == LAST_STEP) state_nxt = DONE;
            DONE: state_nxt = ctrl_MULT ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand load and Booth iteration
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mcand <= '0;
            p_reg <= '0;
            cnt   <= '0;
        end else if (ctrl_MULT) begin
            mcand <= {{(ACC_W-OP_W){data_operandA[OP_W-1]}}, data_operandA};
            p_reg <= {{ACC_W{1'b0}}, data_operandB, 1'b0};
            cnt   <= '0;
        end else if (state == RUN) begin
            p_reg <= p_step;
            cnt   <= cnt + 1'b1;
        end
    end

    // Output registers only change on DONE entry, so no partial values leak out
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mult_result    <= '0;
            mult_exception <= 1'b0;
`ifdef MULT_HI_WORD_EN
            mult_result_hi <= '0;
`endif
        end else if (enter_done) begin
            mult_result    <= product[OP_W-1:0];
            mult_exception <= ovf;
`ifdef MULT_HI_WORD_EN
            mult_result_hi <= product[2*OP_W-1:OP_W];
`endif
        end
    end
endmodule

// File: doc/multiplier.md
# multiplier

Sequential signed 32×32 multiplier, the companion arithmetic unit to the divider in the processor datapath. It uses the same start/ready handshake and shares the same result-mux slot. It computes the 64-bit two's-complement product with radix-4 Booth recoding in 16 iteration cycles. It returns the low 32 bits, plus an overflow exception when the product does not fit in 32 signed bits.

## Interface
Parameters:
- none; widths are fixed by package constants.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- clr  in  1  reset, asynchronous, active-high
- ctrl_MULT  in  1  start strobe; operands sampled on the rising edge where this is high
- data_operandA  in  32  signed multiplicand
- data_operandB  in  32  signed multiplier
- mult_result  out  32  low word of the signed product
- mult_exception  out  1  signed overflow: product[63:31] not all equal
- mult_ready  out  1  one-cycle completion pulse
- mult_result_hi  out  32  high word of the product (only with MULT_HI_WORD_EN)

## Operation
FSM states:
- IDLE
  - ctrl_MULT → RUN: load operands, step counter ← 0.
- RUN
  - Each edge: one Booth step, counter +1.
  - On the edge where counter == 15 → DONE.
  - ctrl_MULT in RUN aborts the current operation and reloads operands; counter ← 0, state stays RUN.
- DONE
  - mult_ready = 1 (Moore output, derived from state only).
  - Next edge → IDLE, unless ctrl_MULT is high, in which case → RUN with the new operands.

Datapath:
- Multiplicand M is sign-extended to 34 bits.
- Product shift register P is 67 bits: {A[33:0], Q[31:0], q₋₁}.
  - On load, A ← 0, Q ← data_operandB, q₋₁ ← 0.
- Each step:
  - Recode {Q[1:0], q₋₁} into a partial-product selector from {0, +M, +2M, −M, −2M}.
  - Add the selected partial product to A in 34 bits.
  - Arithmetic-shift P right by 2.
- After 16 steps, {A[31:0], Q} is the exact 64-bit signed product.

Output registers:
- Product and exception are captured into output registers on the edge entering DONE.
- They are held until the next DONE entry or clr.
- While RUN is in progress, the outputs keep their previous values.
- mult_exception is computed from the full product and is valid whenever mult_ready is high.

Boundary cases:
- Either operand 0 → result 0, exception 0.
- 0x80000000 × 0x80000000 → product 2^62, exception 1.
- Outputs never glitch to partial values.

## Timing
- Start edge N (ctrl_MULT sampled high): mult_ready is high during the cycle following edge N+16 and low again after edge N+17.
- Latency: 16 cycles from start edge to ready.
- Throughput: one operation per 17 cycles. A start in the DONE cycle gives back-to-back operations.
- Async clr:
  - Immediately, without waiting for an edge: state ← IDLE, P ← 0, counter ← 0, mult_result ← 0, mult_exception ← 0, mult_ready ← 0, mult_result_hi ← 0.
  - An operation in flight when clr asserts is discarded; no ready pulse follows.
- ctrl_MULT held high for several cycles restarts the operation on every edge. Ready comes 16 cycles after the last high edge.
- ctrl_MULT while clr is high is ignored.

## Configuration
- MULT_HI_WORD_EN defined:
  - Port mult_result_hi exists and is registered alongside mult_result, giving the high 32 bits of the product.
- Undefined:
  - The port is absent.
  - The high-word output register is not built.
  - mult_exception and mult_result are unchanged.

## Structure
Shared package holds:
- FSM state enum (IDLE, RUN, DONE)
- MULT_STEPS = 16
- Operand width 32 and accumulator width 34
- Booth selector encoding (ZERO, POS1, POS2, NEG1, NEG2)

Sub-module booth_r4_recoder:
- Purely combinational.
- Input: 3-bit window {Q[1:0], q₋₁}.
- Output: the selector enum.
- It is instantiated once.

## Test plan
- 7 × −3 → mult_result 0xFFFFFFEB, exception 0; ready exactly 16 cycles after start, width 1 cycle.
- 0x80000000 × 0xFFFFFFFF → result 0x80000000, exception 1.
- 0x00010000 × 0x00010000 → result 0x00000000, exception 1. With MULT_HI_WORD_EN, mult_result_hi = 0x00000001.
- 0x7FFFFFFF × 1 → 0x7FFFFFFF, exception 0. A back-to-back start of −1 × −1 in the DONE cycle → 0x00000001 after a further 16 cycles.
- Start 5 × 5, then restart with 6 × 7 at cycle 8 → exactly one ready pulse, 16 cycles after the second start, result 42 (0x0000002A).
- clr asserted mid-RUN (cycle 5) → all outputs 0 immediately, no ready pulse afterward. The next start of 3 × 4 → 12.
